// File: rtl/seq_divider_32bit.sv
// Restoring shift-subtract divider, one quotient bit per clock, start/done handshake.
// Define SIGNED_DIV_EN to add the is_signed port and the FIX (sign-correction) cycle.
module seq_divider_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

`ifdef SIGNED_DIV_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_e;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd3} state_e;
`endif

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
`ifdef SIGNED_DIV_EN
    logic             sgn_q, sgn_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
`endif

    logic [WIDTH:0]   shifted_rem;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    // Handshake: start is honoured only in IDLE; done is a one-cycle pulse one
    // cycle after the DONE state, and results hold until the next completion.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        d_d         = d_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = (state_q == S_DONE);
`ifdef SIGNED_DIV_EN
        sgn_d       = sgn_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
`endif

        shifted_rem = {rem_q, quo_q[WIDTH-1]};
        trial       = shifted_rem - {1'b0, d_q};
        rem_nxt     = trial[WIDTH] ? shifted_rem[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nxt     = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        d_d     = divisor;
                        rem_d   = '0;
                        quo_d   = dividend;
                        count_d = '0;
                        dbz_d   = 1'b0;
                        state_d = S_RUN;
`ifdef SIGNED_DIV_EN
                        sgn_d  = is_signed;
                        qneg_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        rneg_d = is_signed & dividend[WIDTH-1];
                        if (is_signed && divisor[WIDTH-1])  d_d   = -divisor;
                        if (is_signed && dividend[WIDTH-1]) quo_d = -dividend;
`endif
                    end
                end
            end
            S_RUN: begin
                rem_d   = rem_nxt;
                quo_d   = quo_nxt;
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
`ifdef SIGNED_DIV_EN
                    if (sgn_q) begin
                        state_d = S_FIX;
                    end else begin
                        quotient_d  = quo_nxt;
                        remainder_d = rem_nxt;
                        state_d     = S_DONE;
                    end
`else
                    quotient_d  = quo_nxt;
                    remainder_d = rem_nxt;
                    state_d     = S_DONE;
`endif
                end
            end
`ifdef SIGNED_DIV_EN
            S_FIX: begin
                quotient_d  = qneg_q ? -quo_q : quo_q;
                remainder_d = rneg_q ? -rem_q : rem_q;
                state_d     = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            d_q         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
`ifdef SIGNED_DIV_EN
            sgn_q       <= 1'b0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            d_q         <= d_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
`ifdef SIGNED_DIV_EN
            sgn_q       <= sgn_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
`endif
        end
    end

`ifdef SIGNED_DIV_EN
    assign busy = (state_q == S_RUN) || (state_q == S_FIX);
`else
    assign busy = (state_q == S_RUN);
`endif
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_32bit.sv
// Randomized self-checking bench for seq_divider_32bit against a plain-arithmetic model.
// Signed cases are included when SIGNED_DIV_EN is defined.
module tb_seq_divider_32bit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
`ifdef SIGNED_DIV_EN
    logic         is_signed = 1'b0;
`endif
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int errors = 0;
    logic [2*W:0] exp_q[$];
    int           lat_q[$];

    seq_divider_32bit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
`ifdef SIGNED_DIV_EN
        .is_signed(is_signed),
`endif
        .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result {div_by_zero, quotient, remainder} from plain arithmetic.
    function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input bit sgn);
        if (b == '0) return {1'b1, {W{1'b1}}, a};
        if (!sgn) return {1'b0, a / b, a % b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, a, {W{1'b0}}};
        return {1'b0, W'($signed(a) / $signed(b)), W'($signed(a) % $signed(b))};
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
        @(negedge clk);
        dividend = a;
        divisor  = b;
`ifdef SIGNED_DIV_EN
        is_signed = sgn;
`endif
        start = 1'b1;
        exp_q.push_back(ref_div(a, b, sgn));
        lat_q.push_back(b == '0 ? 1 : (sgn ? W + 2 : W + 1));
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Latency is counted in clock edges after the accepting edge.
    task automatic wait_result(input int poke_at);
        logic [2*W:0] e;
        logic [W-1:0] held_q, held_r;
        int lat, k, busy_n, hold_bad;
        bit seen;
        e = exp_q.pop_front();
        lat = lat_q.pop_front();
        held_q = quotient;
        held_r = remainder;
        k = 0; busy_n = 0; hold_bad = 0; seen = 0;
        while (!seen && k < 200) begin
            @(negedge clk);
            if (k == poke_at) begin
                start    = 1'b1;
                dividend = $urandom;
                divisor  = $urandom_range(0, 3);
            end
            if (k == poke_at + 1) start = 1'b0;
            if (done) begin
                seen = 1;
            end else begin
                if (busy) busy_n++;
                if (lat > 1 && k <= lat - 2 && (quotient !== held_q || remainder !== held_r))
                    hold_bad++;
                k++;
            end
        end
        if (!seen) begin
            check_eq("done_timeout", 64'd0, 64'd1);
        end else begin
            check_eq("latency", 64'(k), 64'(lat));
            check_eq("busy_cycles", 64'(busy_n), 64'(lat - 1));
            check_eq("hold", 64'(hold_bad), 64'd0);
            check_eq("quotient", 64'(quotient), 64'(e[2*W-1:W]));
            check_eq("remainder", 64'(remainder), 64'(e[W-1:0]));
            check_eq("div_by_zero", 64'(div_by_zero), 64'(e[2*W]));
            @(negedge clk);
            check_eq("done_pulse", 64'(done), 64'd0);
        end
    endtask

    initial begin
        logic [W-1:0] a, b;
        int sel, seen_done;

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_quotient", 64'(quotient), 64'd0);
        check_eq("rst_remainder", 64'(remainder), 64'd0);
        check_eq("rst_dbz", 64'(div_by_zero), 64'd0);

        // Directed cases
        issue(32'd100, 32'd7, 0);        wait_result(-1);
        issue(32'd5, 32'd0, 0);          wait_result(-1);
        issue(32'hFFFF_FFFF, 32'd1, 0);  wait_result(-1);
        issue(32'd0, 32'd3, 0);          wait_result(-1);
        issue(32'd1000, 32'd10, 0);      wait_result(10);

        // Reset mid-RUN aborts with no done pulse
        issue(32'd999, 32'd4, 0);
        void'(exp_q.pop_front());
        void'(lat_q.pop_front());
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        check_eq("abort_quotient", 64'(quotient), 64'd0);
        check_eq("abort_remainder", 64'(remainder), 64'd0);
        check_eq("abort_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check_eq("abort_no_done", 64'(seen_done), 64'd0);
        issue(32'd12345, 32'd67, 0);     wait_result(-1);

        // Randomized unsigned
        for (int i = 0; i < 20; i++) begin
            sel = $urandom_range(0, 9);
            a = (sel == 9) ? W'($urandom_range(0, 50)) : W'($urandom);
            b = (sel == 0) ? '0 : (sel < 5) ? W'($urandom_range(1, 15)) : W'($urandom);
            issue(a, b, 0);
            wait_result(-1);
        end

`ifdef SIGNED_DIV_EN
        issue(32'hFFFF_FFF9, 32'd2, 1);          wait_result(-1);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1);  wait_result(-1);
        issue(32'hFFFF_FFF9, 32'd0, 1);          wait_result(-1);
        issue(32'hFFFF_FFF9, 32'd2, 0);          wait_result(-1);
        for (int i = 0; i < 12; i++) begin
            sel = $urandom_range(0, 9);
            a = $urandom;
            b = (sel == 0) ? '0 : (sel < 5) ? W'($urandom_range(0, 30)) - 32'd15 : W'($urandom);
            issue(a, b, 1);
            wait_result(-1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
